// File: rtl/mux_2_to_1.sv
// Registered two-input selector: captures s0 ? i1 : i0 into o on enabled rising edges,
// along with a copy of the select and a sticky "has captured since reset" flag.
module mux_2_to_1 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             s0,
  output logic [WIDTH-1:0] o,
  output logic             s_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] sel;

  // Whole-word if/else choice, so the two inputs are never blended bit by bit.
  always_comb begin
    sel = i0;
    if (s0) begin
      sel = i1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o       <= RESET_VALUE;
      s_q     <= 1'b0;
      o_valid <= 1'b0;
    end else if (en) begin
      o       <= sel;
      s_q     <= s0;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_2_to_1.sv
// Bench for mux_2_to_1: a 1-bit instance and an 8-bit instance (reset value 8'h7E) share
// clock, reset, enable and select; a queue-based scoreboard checks every captured cycle.
module tb_mux_2_to_1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s0;
  logic [0:0] a_i0, a_i1, a_o;
  logic [7:0] b_i0, b_i1, b_o;
  logic       a_s_q, a_valid, b_s_q, b_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [0:0] o1;
    logic [7:0] o8;
    logic       s;
    logic       v;
  } exp_t;

  exp_t sb_q[$];

  mux_2_to_1 #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .i0(a_i0), .i1(a_i1), .s0(s0),
    .o(a_o), .s_q(a_s_q), .o_valid(a_valid)
  );

  mux_2_to_1 #(.WIDTH(8), .RESET_VALUE(8'h7E)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .i0(b_i0), .i1(b_i1), .s0(s0),
    .o(b_o), .s_q(b_s_q), .o_valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs and queue what both instances must show after the next edge.
  task automatic driveAndPush(input logic e, input logic [0:0] ai0, input logic [0:0] ai1,
                              input logic [7:0] bi0, input logic [7:0] bi1, input logic s,
                              input logic [0:0] x1, input logic [7:0] x8, input logic xs,
                              input logic xv);
    exp_t item;
    en   = e;
    a_i0 = ai0;
    a_i1 = ai1;
    b_i0 = bi0;
    b_i1 = bi1;
    s0   = s;
    item.o1 = x1;
    item.o8 = x8;
    item.s  = xs;
    item.v  = xv;
    sb_q.push_back(item);
  endtask

  task automatic applyStimulus(input logic e, input logic [0:0] ai0, input logic [0:0] ai1,
                               input logic [7:0] bi0, input logic [7:0] bi1, input logic s,
                               input logic [0:0] x1, input logic [7:0] x8, input logic xs,
                               input logic xv);
    @(negedge clk);
    #1;
    driveAndPush(e, ai0, ai1, bi0, bi1, s, x1, x8, xs, xv);
  endtask

  // Monitor: one queued expectation is due at each falling edge after it was issued.
  always @(negedge clk) begin
    exp_t item;
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      checkOutput("sb_o1", {7'b0, a_o}, {7'b0, item.o1});
      checkOutput("sb_o8", b_o, item.o8);
      checkOutput("sb_s_q_a", {7'b0, a_s_q}, {7'b0, item.s});
      checkOutput("sb_s_q_b", {7'b0, b_s_q}, {7'b0, item.s});
      checkOutput("sb_valid_a", {7'b0, a_valid}, {7'b0, item.v});
      checkOutput("sb_valid_b", {7'b0, b_valid}, {7'b0, item.v});
    end
  end

  logic [0:0] tt_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    s0    = 1'b0;
    a_i0  = 1'b0;
    a_i1  = 1'b0;
    b_i0  = 8'h00;
    b_i1  = 8'h00;

    // Reset held while the clock runs.
    repeat (3) begin
      @(negedge clk);
      #2;
      checkOutput("rst_o1", {7'b0, a_o}, 8'h00);
      checkOutput("rst_o8", b_o, 8'h7E);
      checkOutput("rst_s_q", {7'b0, a_s_q}, 8'h00);
      checkOutput("rst_valid", {7'b0, b_valid}, 8'h00);
    end

    // Release with en=1 and all-zero data: first edge captures zeros.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    driveAndPush(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Truth table, order (i0,i1,s0) = 000..111, each held two cycles.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      repeat (2)
        applyStimulus(1'b1, v[2], v[1], 8'h0F, 8'hF0, v[0], tt_exp[i],
                      v[0] ? 8'hF0 : 8'h0F, v[0], 1'b1);
    end

    // Enable hold: capture 1, then change inputs with en=0 for 5 edges.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    repeat (5)
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);

    // Wide data: s0 toggles every cycle, o follows one edge later.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);

    // Between-edge stability: several input changes before the edge leave o at 3C.
    @(negedge clk);
    #1;
    s0 = 1'b0;
    #1;
    checkOutput("stable_1", b_o, 8'h3C);
    b_i1 = 8'h00;
    s0   = 1'b1;
    b_i0 = 8'hFF;
    #1;
    checkOutput("stable_2", b_o, 8'h3C);
    checkOutput("stable_s_q", {7'b0, b_s_q}, 8'h01);
    driveAndPush(1'b1, 1'b0, 1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);

    // Async reset between edges with o = 3C.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h5A, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_o8", b_o, 8'h7E);
    checkOutput("async_o1", {7'b0, a_o}, 8'h00);
    checkOutput("async_valid", {7'b0, b_valid}, 8'h00);
    checkOutput("async_s_q", {7'b0, b_s_q}, 8'h00);
    @(negedge clk);
    #2;
    checkOutput("rst_hold_o8", b_o, 8'h7E);
    checkOutput("rst_hold_valid", {7'b0, a_valid}, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    driveAndPush(1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_2_to_1.md
# mux_2_to_1

Registered two-input, one-output selector. It routes one of two equal-width data words to a single output register, chosen by a one-bit select. The block is the generic path-select primitive in the processor datapath, used for operand, write-back and next-PC selection. It gives every consumer a clean, registered, one-cycle-latency select point.

## Interface
Parameters:
- WIDTH, 1: data width of i0, i1 and o (must be ≥ 1).
- RESET_VALUE, 0: value loaded into o on reset (WIDTH bits, zero-extended or truncated).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- en  input  1  capture enable; when 0 the output register holds its value.
- i0  input  WIDTH  data input, selected when s0 = 0.
- i1  input  WIDTH  data input, selected when s0 = 1.
- s0  input  1  select.
- o  output  WIDTH  registered selected data.
- s_q  output  1  registered copy of s0 captured alongside o, for downstream tagging.
- o_valid  output  1  high once at least one capture has occurred since reset.

## Operation
- Selection function: sel = s0 ? i1 : i0, evaluated on the full WIDTH bits.
- An X or Z on s0 is not a supported condition. The select is treated as a strict 0/1 decision, and no bitwise AND/OR blending of i0 and i1 is allowed.
- On each rising clk edge with rst_n = 1 and en = 1, the following are captured: o ← sel, s_q ← s0, o_valid ← 1.
- With en = 0, o, s_q and o_valid all hold.
- Reset (rst_n = 0) applies asynchronously, independent of clk and en: o ← RESET_VALUE, s_q ← 0, o_valid ← 0.
- Reset values are held for as long as rst_n stays low.
- No other state exists. There is no handshake or backpressure beyond en.

## Timing
- Latency: exactly one clk cycle from i0/i1/s0/en sampled at edge N to o/s_q/o_valid valid after edge N.
- Inputs must be stable for the usual setup/hold window around the rising edge only. Changes between edges have no effect on o, so o is glitch-free.
- Reset assertion takes effect immediately, with no clock required.
- Reset deassertion is released asynchronously. The first capture happens on the first rising edge with rst_n = 1 and en = 1.
- Reset asserted mid-stream discards the in-flight value, and o returns to RESET_VALUE at once.
- Simultaneous changes of s0 and the data on the same cycle: the new s0 selects between the new i0 and i1.
- Full-throughput: a new selection can be captured every cycle.

## Test plan
- Reset: with rst_n = 0 and clk toggling, check o = RESET_VALUE (0), s_q = 0 and o_valid = 0. Release reset with en = 1, i0 = 0, i1 = 0, s0 = 0, and check o = 0 and o_valid = 1 after the first edge.
- Exhaustive truth table (WIDTH = 1, en = 1): step through all 8 combinations of (i0, i1, s0) in order 000, 001, 010, 011, 100, 101, 110, 111, holding each for several cycles. The required o after the next edge is 0, 0, 0, 1, 1, 0, 1, 1.
- Enable hold: capture o = 1 (i0 = 1, s0 = 0). Then set en = 0 and change to i0 = 0, i1 = 0, s0 = 1. Check that o stays 1 and s_q stays 0 across 5 edges, then updates to 0 and 1 one edge after en = 1.
- Wide data (WIDTH = 8): drive i0 = 8'hA5, i1 = 8'h3C, toggle s0 every cycle, and check o alternates A5/3C, lagging s0 by exactly one cycle.
- Async reset mid-operation (WIDTH = 8, RESET_VALUE = 8'h7E): with o = 8'h3C, pulse rst_n low between clock edges. Check that o = 7E and o_valid = 0 immediately, with no edge required.
- Between-edge stability: change s0 and the data several times within one clock period and check that o does not change until the next rising edge.
